hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  in  1  single pipeline clock; all state updates on its rising edge.
REQ-002 reset  in  1  asynchronous, active-low; low clears all state immediately.
REQ-003 rs_adr_id, rt_adr_id  in  3 each  source register addresses of the instruction in ID.
REQ-004 uses_rs_id, uses_rt_id  in  1 each  the ID instruction reads rs / rt.
REQ-005 regwrite_adr_ex  in  3  destination register of the instruction in EX.
REQ-006 regwrite_ex  in  1  the EX instruction writes the register file.
REQ-007 regwrite_dat_controll_ex  in  2  write-data source of the EX instruction; 2'b01 = main-memory load.
REQ-008 branch_taken_ex  in  1  EX resolved a taken branch or jump this cycle.
REQ-009 is_halt_ex  in  1  HALT instruction is in EX.
REQ-010 mem_busy  in  1  main memory is not ready; the whole pipeline must freeze.
REQ-011 restart  in  1  one-cycle pulse that resumes from HALT.
REQ-012 en_pc, en_ifid, en_idex  out  1 each  pipeline register enables.
REQ-013 flush_ifid, flush_idex  out  1 each  synchronous bubble insertion into IF/ID and ID/EX.
REQ-014 halted  out  1  core is in HALT.
REQ-015 stall_cnt  out  16  stall-cycle counter (see Configuration).

Function
REQ-016 States: RUN, HALT, RESUME; encoding is free, and every unused encoding shall go to RUN.
REQ-017 Load-use hazard = regwrite_ex & (regwrite_dat_controll_ex==2'b01) & ((uses_rs_id & rs_adr_id==regwrite_adr_ex) | (uses_rt_id & rt_adr_id==regwrite_adr_ex)).
REQ-018 RUN priority, highest first: mem_busy, is_halt_ex, branch_taken_ex, load-use, normal.
REQ-019 RUN + mem_busy: all enables 0, all flushes 0; the state stays RUN.
REQ-020 RUN + is_halt_ex: en_pc=0, en_ifid=0, en_idex=1, flush_ifid=1, flush_idex=1; the next state is HALT.
REQ-021 RUN + branch_taken_ex: all enables 1, flush_ifid=1, flush_idex=1, giving a two-bubble penalty.
REQ-022 RUN + load-use: en_pc=0, en_ifid=0, en_idex=1, flush_idex=1, flush_ifid=0, giving exactly one bubble.
REQ-023 RUN, normal: all enables 1, all flushes 0.
REQ-024 HALT: all enables 0, all flushes 0, halted=1; all inputs other than restart and reset are ignored.
REQ-025 HALT + restart: the next state is RESUME.
REQ-026 RESUME (one cycle): all enables 1, flush_ifid=1, flush_idex=1, halted=0; the next state is RUN unconditionally.
REQ-027 restart outside HALT shall have no effect.
REQ-028 halted is registered and equals (state==HALT); all other outputs are combinational from the state and current inputs.
REQ-029 A stall cycle is any cycle with en_pc=0 and state≠HALT.

Reset
REQ-030 While reset is low: state=RUN, halted=0, stall_cnt=0, all enables 0, all flushes 0.
REQ-031 Reset asserted in any state, including HALT, shall return the state to RUN at once; the first rising edge after reset deasserts behaves as RUN.

Configuration
REQ-032 Macro HAZARD_STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each stall cycle and saturates at 16'hFFFF (no wrap).
- Not defined: stall_cnt is tied to 16'h0000 and no counter flops are synthesised.

Verification
REQ-033 Load-use: EX holds a load (regwrite_ex=1, ctrl=2'b01, adr=3), ID holds uses_rs_id=1, rs_adr_id=3 -> exactly one cycle with en_pc=0, flush_idex=1; stall_cnt=1 when enabled.
REQ-034 Branch and load-use in the same cycle -> branch wins: en_pc=1, flush_ifid=1, flush_idex=1; stall_cnt unchanged.
REQ-035 mem_busy high for 5 cycles, with is_halt_ex also high -> 5 frozen cycles, no flushes, state stays RUN; the halt is taken on the first cycle after mem_busy drops; stall_cnt+=5.
REQ-036 is_halt_ex pulse -> halted=1 from the next cycle; restart after 10 cycles -> one RESUME cycle with both flushes, then RUN; stall_cnt counts only the halt-entry cycle (+1).
REQ-037 Reset pulsed low mid-HALT -> halted=0 and stall_cnt=0 immediately, without waiting for a clock edge; normal RUN after release.
REQ-038 Counter saturation (macro defined): force 65540 stall cycles -> stall_cnt holds 16'hFFFF; with the macro undefined, stall_cnt stays 0.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard unit bus: ID/EX hazard sources in, pipeline enables/flushes out.
// master = pipeline side (drives hazard sources), slave = hazard unit.
interface hazard_unit_if;
  logic [2:0]  rs_adr_id;
  logic [2:0]  rt_adr_id;
  logic        uses_rs_id;
  logic        uses_rt_id;
  logic [2:0]  regwrite_adr_ex;
  logic        regwrite_ex;
  logic [1:0]  regwrite_dat_controll_ex;
  logic        branch_taken_ex;
  logic        is_halt_ex;
  logic        mem_busy;
  logic        restart;
  logic        en_pc;
  logic        en_ifid;
  logic        en_idex;
  logic        flush_ifid;
  logic        flush_idex;
  logic        halted;
  logic [15:0] stall_cnt;

  modport master (
    output rs_adr_id, rt_adr_id, uses_rs_id, uses_rt_id, regwrite_adr_ex,
           regwrite_ex, regwrite_dat_controll_ex, branch_taken_ex,
           is_halt_ex, mem_busy, restart,
    input  en_pc, en_ifid, en_idex, flush_ifid, flush_idex, halted, stall_cnt
  );

  modport slave (
    input  rs_adr_id, rt_adr_id, uses_rs_id, uses_rt_id, regwrite_adr_ex,
           regwrite_ex, regwrite_dat_controll_ex, branch_taken_ex,
           is_halt_ex, mem_busy, restart,
    output en_pc, en_ifid, en_idex, flush_ifid, flush_idex, halted, stall_cnt
  );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: memory freeze, HALT/RESUME, branch flush, load-use stall.
// Optional macro HAZARD_STALL_CNT_EN adds a saturating 16-bit stall-cycle counter;
// without it stall_cnt is tied to zero.
module hazard_unit (
  input  logic          clk,
  input  logic          reset,   // async, active low
  hazard_unit_if.slave  hz
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    HALT   = 2'b01,
    RESUME = 2'b10
  } state_t;

  state_t r_state;
  logic   r_halted;

  logic w_load_use;
  logic w_en_pc, w_en_ifid, w_en_idex, w_flush_ifid, w_flush_idex;

  // Load in EX whose destination is read by the instruction in ID
  assign w_load_use = hz.regwrite_ex && (hz.regwrite_dat_controll_ex == 2'b01) &&
                      ((hz.uses_rs_id && (hz.rs_adr_id == hz.regwrite_adr_ex)) ||
                       (hz.uses_rt_id && (hz.rt_adr_id == hz.regwrite_adr_ex)));

  // Enables/flushes from state and current inputs; forced quiet while in reset
  always_comb begin
    w_en_pc      = 1'b0;
    w_en_ifid    = 1'b0;
    w_en_idex    = 1'b0;
    w_flush_ifid = 1'b0;
    w_flush_idex = 1'b0;
    if (reset) begin
      case (r_state)
        RUN: begin
          if (hz.mem_busy) begin
            // full freeze, everything stays 0
          end else if (hz.is_halt_ex) begin
            // let HALT drain out of EX, kill the younger instructions
            w_en_idex    = 1'b1;
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
          end else if (hz.branch_taken_ex) begin
            w_en_pc      = 1'b1;
            w_en_ifid    = 1'b1;
            w_en_idex    = 1'b1;
            w_flush_ifid = 1'b1;
            w_flush_idex = 1'b1;
          end else if (w_load_use) begin
            // hold PC and IF/ID, push a single bubble into ID/EX
            w_en_idex    = 1'b1;
            w_flush_idex = 1'b1;
          end else begin
            w_en_pc      = 1'b1;
            w_en_ifid    = 1'b1;
            w_en_idex    = 1'b1;
          end
        end
        HALT: begin
          // frozen, only restart/reset matter
        end
        RESUME: begin
          w_en_pc      = 1'b1;
          w_en_ifid    = 1'b1;
          w_en_idex    = 1'b1;
          w_flush_ifid = 1'b1;
          w_flush_idex = 1'b1;
        end
        default: begin
          // unreachable encodings: stay quiet, FSM recovers to RUN
        end
      endcase
    end
  end

  // State register; halted is registered alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RUN;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (!hz.mem_busy && hz.is_halt_ex) begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end else begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
        HALT: begin
          if (hz.restart) begin
            r_state  <= RESUME;
            r_halted <= 1'b0;
          end else begin
            r_state  <= HALT;
            r_halted <= 1'b1;
          end
        end
        RESUME: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
        default: begin
          r_state  <= RUN;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic        w_stall;
  logic [15:0] r_stall_cnt;

  assign w_stall = !w_en_pc && (r_state != HALT);

  // Saturating count of stall cycles (PC held outside HALT)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   r_stall_cnt <= 16'h0000;
    else if (w_stall && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'h0001;
  end

  assign hz.stall_cnt = r_stall_cnt;
`else
  assign hz.stall_cnt = 16'h0000;
`endif

  assign hz.en_pc      = w_en_pc;
  assign hz.en_ifid    = w_en_ifid;
  assign hz.en_idex    = w_en_idex;
  assign hz.flush_ifid = w_flush_ifid;
  assign hz.flush_idex = w_flush_idex;
  assign hz.halted     = r_halted;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit with an expectation scoreboard.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_hazard_unit;

`ifdef HAZARD_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  hazard_unit_if bus ();
  hazard_unit dut (.clk(clk), .reset(reset), .hz(bus));

  typedef struct packed {
    logic [2:0] rs, rt;
    logic       urs, urt;
    logic [2:0] wadr;
    logic       wr;
    logic [1:0] ctrl;
    logic       br, halt, busy, rst;
  } in_t;

  // {en_pc, en_ifid, en_idex, flush_ifid, flush_idex, halted}
  typedef logic [5:0] exp_t;
  localparam exp_t E_NORM   = 6'b111_00_0;
  localparam exp_t E_FREEZE = 6'b000_00_0;
  localparam exp_t E_HIN    = 6'b001_11_0;
  localparam exp_t E_BR     = 6'b111_11_0;
  localparam exp_t E_LU     = 6'b001_01_0;
  localparam exp_t E_HLT    = 6'b000_00_1;
  localparam exp_t E_RES    = 6'b111_11_0;
  localparam exp_t E_RST    = 6'b000_00_0;

  typedef struct {
    string       tag;
    exp_t        e;
    logic [15:0] cnt;
    bit          stall;
  } sb_t;

  sb_t         sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'h0000;

  in_t IDLE, LD_RS, LD_RT, LD_MISS, NOLOAD, NOUSE, NOWR, BR_LD, BUSY, BUSY_HALT,
       HALT_ONLY, JUNK, RESTART;

  task automatic drive(input in_t v);
    bus.rs_adr_id                = v.rs;
    bus.rt_adr_id                = v.rt;
    bus.uses_rs_id               = v.urs;
    bus.uses_rt_id               = v.urt;
    bus.regwrite_adr_ex          = v.wadr;
    bus.regwrite_ex              = v.wr;
    bus.regwrite_dat_controll_ex = v.ctrl;
    bus.branch_taken_ex          = v.br;
    bus.is_halt_ex               = v.halt;
    bus.mem_busy                 = v.busy;
    bus.restart                  = v.rst;
  endtask

  task automatic push(input string tag, input exp_t e, input bit stall);
    sb_t s;
    s.tag = tag; s.e = e; s.cnt = exp_cnt; s.stall = stall;
    sb_q.push_back(s);
  endtask

  task automatic pop_cmp();
    sb_t  s;
    exp_t obs;
    s   = sb_q.pop_front();
    obs = {bus.en_pc, bus.en_ifid, bus.en_idex, bus.flush_ifid, bus.flush_idex, bus.halted};
    n_checks++;
    assert (obs === s.e) else begin
      n_fail++;
      $error("FAIL %s outs: got %b want %b", s.tag, obs, s.e);
    end
    n_checks++;
    assert (bus.stall_cnt === s.cnt) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: got %h want %h", s.tag, bus.stall_cnt, s.cnt);
    end
    // the stall this cycle shows up in the counter after the next rising edge
    if (s.stall && CNT_EN && exp_cnt != 16'hFFFF) exp_cnt++;
  endtask

  // one cycle: drive, expect, compare
  task automatic step(input string tag, input in_t v, input exp_t e);
    @(negedge clk);
    drive(v);
    push(tag, e, !e[5] && !e[0]);
    #1;
    pop_cmp();
  endtask

  // hold mem_busy for n rising edges without per-cycle checks
  task automatic run_busy(input int n);
    @(negedge clk);
    drive(BUSY);
    repeat (n) begin
      @(posedge clk);
      if (CNT_EN && exp_cnt != 16'hFFFF) exp_cnt++;
    end
  endtask

  initial begin
    IDLE = '0;
    LD_RS = IDLE;   LD_RS.wr = 1; LD_RS.ctrl = 2'b01; LD_RS.wadr = 3'd3; LD_RS.urs = 1; LD_RS.rs = 3'd3;
    LD_RT = IDLE;   LD_RT.wr = 1; LD_RT.ctrl = 2'b01; LD_RT.wadr = 3'd5; LD_RT.urt = 1; LD_RT.rt = 3'd5;
                    LD_RT.urs = 1; LD_RT.rs = 3'd2;
    LD_MISS = LD_RS; LD_MISS.rs = 3'd4;
    NOLOAD = LD_RS;  NOLOAD.ctrl = 2'b10;
    NOUSE  = LD_RS;  NOUSE.urs = 0;
    NOWR   = LD_RS;  NOWR.wr = 0;
    BR_LD  = LD_RS;  BR_LD.br = 1;
    BUSY   = IDLE;   BUSY.busy = 1;
    BUSY_HALT = BUSY; BUSY_HALT.halt = 1;
    HALT_ONLY = IDLE; HALT_ONLY.halt = 1;
    JUNK = BR_LD;    JUNK.halt = 1; JUNK.busy = 1;
    RESTART = IDLE;  RESTART.rst = 1;

    drive(IDLE);
    #1;
    push("reset_init", E_RST, 0);
    pop_cmp();
    @(negedge clk);
    reset = 1'b1;

    step("normal", IDLE, E_NORM);
    // load-use on rs: exactly one bubble
    step("lu_rs", LD_RS, E_LU);
    step("lu_rs_after", IDLE, E_NORM);
    step("lu_rt", LD_RT, E_LU);
    step("lu_rt_after", IDLE, E_NORM);
    // near-misses: no stall
    step("lu_addr_miss", LD_MISS, E_NORM);
    step("lu_not_load", NOLOAD, E_NORM);
    step("lu_no_use", NOUSE, E_NORM);
    step("lu_no_write", NOWR, E_NORM);
    // branch beats load-use
    step("branch_lu", BR_LD, E_BR);
    step("branch_after", IDLE, E_NORM);
    // memory freeze masks a pending halt for 5 cycles
    for (int i = 0; i < 5; i++) step("busy_halt", BUSY_HALT, E_FREEZE);
    step("halt_entry", HALT_ONLY, E_HIN);
    for (int i = 0; i < 10; i++) step("halted_ignore", JUNK, E_HLT);
    step("halt_restart", RESTART, E_HLT);
    step("resume", IDLE, E_RES);
    step("run_after_resume", IDLE, E_NORM);
    // restart outside HALT does nothing
    step("restart_in_run", RESTART, E_NORM);
    step("restart_in_run2", IDLE, E_NORM);
    // async reset in the middle of HALT
    step("halt_entry2", HALT_ONLY, E_HIN);
    step("halted2", IDLE, E_HLT);
    #2 reset = 1'b0;
    exp_cnt = 16'h0000;
    #1;
    push("reset_mid_halt", E_RST, 0);
    pop_cmp();
    @(negedge clk);
    reset = 1'b1;
    step("run_after_reset", IDLE, E_NORM);
    step("lu_after_reset", LD_RS, E_LU);
    // long freeze: counter saturates when present, stays 0 otherwise
    run_busy(CNT_EN ? 65540 : 40);
    step("cnt_saturate", BUSY, E_FREEZE);
    step("cnt_hold", LD_RS, E_LU);
    step("cnt_final", IDLE, E_NORM);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
